// File: rtl/ysyx_22050612_pkg.sv
// rtl/ysyx_22050612_pkg.sv - shared widths, reset PC and IFU state encoding
package ysyx_22050612_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_DROP = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22050612_Reg.sv
// rtl/ysyx_22050612_Reg.sv - generic register with write enable and reset value
module ysyx_22050612_Reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;

    // Next value: new data when written, otherwise hold.
    always_comb begin
        dout_d = dout_q;
        if (we) begin
            dout_d = din;
        end
    end

    // Storage with synchronous reset to the configured value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= RESET_VAL;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// rtl/ysyx_22050612_ifu.sv - instruction fetch unit (optional trace: YSYX_22050612_IFU_TRACE_EN)
module ysyx_22050612_ifu
    import ysyx_22050612_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    ifu_state_e         state_q;
    ifu_state_e         state_d;
    logic [INST_W-1:0]  inst_q;
    logic [INST_W-1:0]  inst_d;
    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    pc_d;
    logic               pc_we;
    logic               req_fire;
    logic               idu_fire;

    ysyx_22050612_Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (pc_we),
        .din   (pc_d),
        .dout  (pc_q)
    );

    // A redirect suppresses both handshakes in the same cycle; rst_n gating
    // keeps both valids low for the whole reset window.
    assign imem_req_valid = rst_n & (state_q == IFU_REQ)  & ~redirect_valid;
    assign inst_valid     = rst_n & (state_q == IFU_HOLD) & ~redirect_valid;
    assign imem_req_addr  = pc_q;
    assign inst           = inst_q;
    assign inst_pc        = pc_q;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign idu_fire = inst_valid & inst_ready;

    // Next-state, held instruction and PC update; redirect has top priority.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pc_we   = 1'b0;
        pc_d    = pc_q + 64'd4;

        if (redirect_valid) begin
            pc_we = 1'b1;
            pc_d  = align4(redirect_pc);
        end else if (idu_fire) begin
            pc_we = 1'b1;
        end

        case (state_q)
            IFU_REQ: begin
                if (req_fire) begin
                    state_d = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (redirect_valid) begin
                    // Same-cycle response is the stale word itself, so nothing left to drop.
                    state_d = imem_rsp_valid ? IFU_REQ : IFU_DROP;
                end else if (imem_rsp_valid) begin
                    inst_d  = imem_rsp_data;
                    state_d = IFU_HOLD;
                end
            end
            IFU_DROP: begin
                // The outstanding response is always consumed here so the
                // unit cannot wait for a response that will never come.
                if (imem_rsp_valid) begin
                    state_d = IFU_REQ;
                end
            end
            IFU_HOLD: begin
                if (redirect_valid || idu_fire) begin
                    state_d = IFU_REQ;
                end
            end
            default: state_d = IFU_REQ;
        endcase
    end

    // FSM state and held instruction registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IFU_REQ;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
        end
    end

`ifdef YSYX_22050612_IFU_TRACE_EN
    logic [63:0] count_q;
    logic [63:0] count_d;

    // Retired-fetch count advances on each IDU handshake.
    always_comb begin
        count_d = count_q;
        if (idu_fire) begin
            count_d = count_q + 64'd1;
        end
    end

    // Counter storage plus fetch and redirect trace output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (idu_fire) begin
                $display("ifu %x %x %d", inst_pc, inst, count_d);
            end
            if (redirect_valid) begin
                $display("ifu redirect %x", align4(redirect_pc));
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// tb/tb_ysyx_22050612_ifu.sv - vector table and randomized reference check of the IFU
module tb_ysyx_22050612_ifu;

    localparam logic [63:0] R = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int passed = 0;
    int total  = 0;

    ysyx_22050612_ifu #(.RESET_PC(R)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        rspv;
        logic [31:0] rspd;
        logic        irdy;
        logic        rdv;
        logic [63:0] rdpc;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_ipc;
        logic        full;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic rdy, input logic rspv, input logic [31:0] rspd,
                       input logic irdy, input logic rdv, input logic [63:0] rdpc,
                       input logic erv, input logic [63:0] ea, input logic eiv,
                       input logic [31:0] ei, input logic [63:0] eip, input logic full);
        vec_t v;
        v.rst_n = r;   v.rdy = rdy;   v.rspv = rspv; v.rspd = rspd;
        v.irdy = irdy; v.rdv = rdv;   v.rdpc = rdpc;
        v.e_rv = erv;  v.e_addr = ea; v.e_iv = eiv;  v.e_inst = ei;
        v.e_ipc = eip; v.full = full;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference memory contents: a fixed hash of the address.
    function automatic logic [31:0] memw(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    logic [63:0] exp_pc;
    logic [63:0] pend_addr;
    int          pend;
    int          pend_cnt;
    int          retired;

    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // r rdy rspv rspd irdy rdv rdpc | erv addr eiv inst ipc full
        add(0,0,0,0,0,0,0,                 0,R,0,0,R,1);
        add(1,1,0,0,0,0,0,                 1,R,0,0,0,0);
        add(1,0,1,32'h0000_0413,0,0,0,     0,0,0,0,0,0);
        add(1,0,0,0,1,0,0,                 0,0,1,32'h0000_0413,R,0);
        add(1,1,0,0,0,0,0,                 1,R+4,0,0,0,0);
        add(1,0,1,32'h0010_0093,0,0,0,     0,0,0,0,0,0);
        for (int i = 0; i < 5; i++)
            add(1,0,0,0,0,0,0,             0,0,1,32'h0010_0093,R+4,0);
        add(1,0,0,0,1,0,0,                 0,0,1,32'h0010_0093,R+4,0);
        for (int i = 0; i < 4; i++)
            add(1,0,0,0,0,0,0,             1,R+8,0,0,0,0);
        add(1,1,0,0,0,0,0,                 1,R+8,0,0,0,0);
        add(1,0,0,0,0,1,R+64'h100,         0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,                 0,0,0,0,0,0);
        add(1,0,1,32'hDEAD_BEEF,0,0,0,     0,0,0,0,0,0);
        add(1,1,0,0,0,0,0,                 1,R+64'h100,0,0,0,0);
        add(1,0,1,32'h0000_0013,0,0,0,     0,0,0,0,0,0);
        add(1,0,0,0,1,1,R+64'h203,         0,0,0,0,0,0);
        add(1,1,0,0,0,0,0,                 1,R+64'h200,0,0,0,0);
        add(1,0,0,0,0,0,0,                 0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,                 0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,                 0,R,0,0,R,1);
        add(1,0,0,0,0,0,0,                 1,R,0,0,0,0);
        add(1,0,1,32'hBAD0_BAD0,0,0,0,     1,R,0,0,0,0);
        add(1,1,0,0,0,0,0,                 1,R,0,0,0,0);
        add(1,0,1,32'h0000_0513,0,0,0,     0,0,0,0,0,0);
        add(1,0,0,0,1,0,0,                 0,0,1,32'h0000_0513,R,0);
        add(1,1,0,0,0,1,64'hFFFF_FFFF_FFFF_FFFE, 0,0,0,0,0,0);
        add(1,1,0,0,0,0,0,                 1,64'hFFFF_FFFF_FFFF_FFFC,0,0,0,0);
        add(1,0,1,32'h0000_0093,0,0,0,     0,0,0,0,0,0);
        add(1,0,0,0,1,0,0,                 0,0,1,32'h0000_0093,64'hFFFF_FFFF_FFFF_FFFC,0);
        add(1,0,0,0,0,0,0,                 1,64'h0,0,0,0,0);

        repeat (3) @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst_n          = vq[i].rst_n;
            imem_req_ready = vq[i].rdy;
            imem_rsp_valid = vq[i].rspv;
            imem_rsp_data  = vq[i].rspd;
            inst_ready     = vq[i].irdy;
            redirect_valid = vq[i].rdv;
            redirect_pc    = vq[i].rdpc;
            #1;
            chk($sformatf("row%0d req_valid", i), 64'(imem_req_valid), 64'(vq[i].e_rv));
            chk($sformatf("row%0d inst_valid", i), 64'(inst_valid), 64'(vq[i].e_iv));
            if (vq[i].e_rv || vq[i].full)
                chk($sformatf("row%0d req_addr", i), imem_req_addr, vq[i].e_addr);
            if (vq[i].e_iv || vq[i].full) begin
                chk($sformatf("row%0d inst", i), 64'(inst), 64'(vq[i].e_inst));
                chk($sformatf("row%0d inst_pc", i), inst_pc, vq[i].e_ipc);
            end
        end

        // Randomized run against a transaction-level model: every accepted
        // request and every retired instruction must carry the next expected PC.
        @(negedge clk);
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_pc = R; pend = 0; pend_cnt = 0; pend_addr = '0; retired = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge clk);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (pend != 0 && pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memw(pend_addr);
            end
            imem_req_ready = ($urandom % 3) != 0;
            inst_ready     = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 20) == 0;
            redirect_pc    = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 65535))};
            #1;
            if (redirect_valid)
                chk("rnd redirect_quiet", 64'({imem_req_valid, inst_valid}), 64'd0);
            if (imem_rsp_valid) pend = 0;
            else if (pend != 0) pend_cnt--;
            if (imem_req_valid && imem_req_ready) begin
                chk("rnd one_outstanding", 64'(pend), 64'd0);
                chk("rnd req_addr", imem_req_addr, exp_pc);
                pend      = 1;
                pend_cnt  = $urandom_range(0, 3);
                pend_addr = imem_req_addr;
            end
            if (inst_valid && inst_ready) begin
                chk("rnd inst_pc", inst_pc, exp_pc);
                chk("rnd inst", 64'(inst), 64'(memw(exp_pc)));
                exp_pc = exp_pc + 64'd4;
                retired++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
        end
        chk("rnd liveness", 64'(retired > 150), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
